// File: rtl/deca_vip_onchip_memory3.sv
// deca_vip_onchip_memory3: parametrised Avalon-MM on-chip RAM slave.
// Provides a pipelined read path with readdatavalid, a post-reset zero-fill
// engine and out-of-range access flagging.
//
// Handshake: a command is accepted on a rising edge when chipselect and
// (read or write) are high and waitrequest is low during the preceding cycle.
// Read data returns in order, one word per accepted read. readdatavalid is
// forced low while stalled, so a return is never observed twice.
module deca_vip_onchip_memory3 #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 15,
    parameter int DEPTH          = 17500,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    input  logic                  reset_req,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  clear_busy,
    output logic                  oor_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic               s1_v_q, s1_v_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  readdata_q, readdata_d;
    logic               oor_q, oor_d;

    logic               stall;
    logic               accept;
    logic               acc_wr;
    logic               acc_rd;
    logic               addr_oor;
    logic [IDX_W-1:0]   addr_idx;
    logic [DATA_W-1:0]  rd_word;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [BE_W-1:0]    mem_be;
    logic [DATA_W-1:0]  mem_wdata;

    // Command decode and combinational status outputs.
    always_comb begin
        stall         = ~clken | reset_req;
        clear_busy    = (state_q == ST_CLEAR);
        waitrequest   = clear_busy | stall;
        accept        = chipselect & (read | write) & ~waitrequest;
        acc_wr        = accept & write;
        acc_rd        = accept & read & ~write;   // write wins when both set
        addr_oor      = ({1'b0, address} >= DEPTH_X);
        addr_idx      = address[IDX_W-1:0];
        rd_word       = addr_oor ? '0 : mem[addr_idx];
        readdatavalid = rvalid_q & ~stall;
        readdata      = readdata_q;
        oor_err       = oor_q;
    end

    // Zero-fill FSM: walk clr_addr over the array, then hand over to RUN.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR && !stall) begin
            if (clr_addr_q == LAST_ADDR) begin
                state_d    = ST_RUN;
                clr_addr_d = '0;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
    end

    // Array write port: the clear engine and host writes never coincide
    // because host commands are held off while clearing.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = addr_idx;
        mem_be    = byteenable;
        mem_wdata = writedata;
        if (state_q == ST_CLEAR && !stall) begin
            mem_we    = 1'b1;
            mem_idx   = clr_addr_q[IDX_W-1:0];
            mem_be    = '1;
            mem_wdata = '0;
        end else if (acc_wr && !addr_oor) begin
            mem_we    = 1'b1;
        end
    end

    // Read return pipeline; every stage freezes while stalled.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_data_d  = s1_data_q;
        rvalid_d   = rvalid_q;
        readdata_d = readdata_q;
        oor_d      = accept & addr_oor;
        if (!stall) begin
            if (READ_LATENCY == 1) begin
                s1_v_d   = 1'b0;
                rvalid_d = acc_rd;
                if (acc_rd) begin
                    readdata_d = rd_word;
                end
            end else begin
                s1_v_d   = acc_rd;
                rvalid_d = s1_v_q;
                if (acc_rd) begin
                    s1_data_d = rd_word;
                end
                if (s1_v_q) begin
                    readdata_d = s1_data_q;
                end
            end
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
            s1_v_q     <= 1'b0;
            s1_data_q  <= '0;
            rvalid_q   <= 1'b0;
            readdata_q <= '0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            s1_v_q     <= s1_v_d;
            s1_data_q  <= s1_data_d;
            rvalid_q   <= rvalid_d;
            readdata_q <= readdata_d;
            oor_q      <= oor_d;
        end
    end

    // Byte-lane masked storage array (no reset; cleared by the FSM).
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

endmodule
